bit_serial_sub: RTL and testbench



---
 rtl/bit_serial_sub.sv | 118 +++++++++++
 tb/tb_bit_serial_sub.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_sub.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first, with a
// registered borrow chain. Start/done handshake; result held until the next
// completion.
// Optional feature: define SUB_SIGNED_OVF_EN to compute the signed overflow
// flag on ovf; when undefined ovf is tied low and no sign registers exist.
module bit_serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  // Handshake: start is accepted on a rising edge while state is IDLE or DONE
  // (back-to-back allowed); it is ignored while busy. done is a one-cycle
  // pulse decoded from registered state, never combinationally from start.

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // state is left visible so checkers can bind to it directly.
  state_t state, state_next;

  logic [WIDTH-1:0] sa, sb, res;
  logic             bw;
  logic [CW-1:0]    cnt;
  logic             accept, last, d, bw_next;

  assign accept  = start && ((state == IDLE) || (state == DONE));
  assign last    = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
  assign d       = sa[0] ^ sb[0] ^ bw;
  assign bw_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bw);
  assign busy    = (state == SHIFT);
  assign done    = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: IDLE -> SHIFT on start, SHIFT -> DONE after the last
  // bit, DONE -> SHIFT on start (back-to-back) or back to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last)  state_next = DONE;
      DONE:    state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand shift registers, borrow chain, bit counter and partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa  <= '0;
      sb  <= '0;
      res <= '0;
      bw  <= 1'b0;
      cnt <= '0;
    end else if (accept) begin
      sa  <= a;
      sb  <= b;
      res <= '0;
      bw  <= 1'b0;
      cnt <= '0;
    end else if (state == SHIFT) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      res <= {d, res[WIDTH-1:1]};
      bw  <= bw_next;
      cnt <= cnt + CW'(1);
    end
  end

  // Result registers update only on the edge that processes the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (last) begin
      diff       <= {d, res[WIDTH-1:1]};
      borrow_out <= bw_next;
    end
  end

`ifdef SUB_SIGNED_OVF_EN
  logic a_msb, b_msb;

  // Capture operand sign bits at accept; the shift registers lose them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (accept) begin
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end
      // The bit produced on the last edge is the result sign bit.
      if (last) ovf <= (a_msb ^ b_msb) & (d ^ a_msb);
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_bit_serial_sub.sv
// Self-checking bench for bit_serial_sub: a WIDTH=8 instance for directed and
// random traffic and a WIDTH=4 instance for an exhaustive operand sweep.
module tb_bit_serial_sub;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       start8 = 1'b0, start4 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, diff8;
  logic [3:0] a4 = '0, b4 = '0, diff4;
  logic       busy8, done8, bor8, ovf8;
  logic       busy4, done4, bor4, ovf4;

  bit_serial_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bor8), .ovf(ovf8)
  );

  bit_serial_sub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bor4), .ovf(ovf4)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [9:0] exp8_q[$];   // {ovf, borrow, diff[7:0]}
  logic [9:0] exp4_q[$];
  int since8 = 1000;       // rising edges since the last modelled accept
  int since4 = 1000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain modular / signed integer arithmetic.
  function automatic logic [9:0] ref_sub(input int w, input int x, input int y);
    int   mask = (1 << w) - 1;
    int   half = 1 << (w - 1);
    int   dv   = (x - y) & mask;
    int   sx   = (x >= half) ? x - (1 << w) : x;
    int   sy   = (y >= half) ? y - (1 << w) : y;
    int   s    = sx - sy;
    logic o    = 1'b0;
    logic br   = (x < y);
    logic [7:0] dd = 8'(dv);
`ifdef SUB_SIGNED_OVF_EN
    o = (s < -half) || (s > half - 1);
`endif
    return {o, br, dd};
  endfunction

  // Acceptance model: a new start is taken once the previous operation has
  // used its WIDTH shift cycles plus the single done cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      since8 = 1000;
      since4 = 1000;
      exp8_q.delete();
      exp4_q.delete();
    end else begin
      since8 = since8 + 1;
      if (start8 && since8 >= 9) begin
        exp8_q.push_back(ref_sub(8, int'(a8), int'(b8)));
        since8 = 0;
      end
      since4 = since4 + 1;
      if (start4 && since4 >= 5) begin
        exp4_q.push_back(ref_sub(4, int'(a4), int'(b4)));
        since4 = 0;
      end
    end
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("busy8", 32'(busy8), 32'(since8 < 8));
      check("done8", 32'(done8), 32'(since8 == 8));
      if (done8 === 1'b1) begin
        if (exp8_q.size() == 0) check("done8_unexpected", 32'(done8), 32'd0);
        else begin
          logic [9:0] e;
          e = exp8_q.pop_front();
          check("diff8", 32'(diff8), 32'(e[7:0]));
          check("borrow8", 32'(bor8), 32'(e[8]));
          check("ovf8", 32'(ovf8), 32'(e[9]));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("busy4", 32'(busy4), 32'(since4 < 4));
      check("done4", 32'(done4), 32'(since4 == 4));
      if (done4 === 1'b1) begin
        if (exp4_q.size() == 0) check("done4_unexpected", 32'(done4), 32'd0);
        else begin
          logic [9:0] e;
          e = exp4_q.pop_front();
          check("diff4", 32'(diff4), 32'(e[3:0]));
          check("borrow4", 32'(bor4), 32'(e[8]));
          check("ovf4", 32'(ovf4), 32'(e[9]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue8(input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    a8 = x; b8 = y; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (9) @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy8), 32'd0);
    check({tag, "_done"}, 32'(done8), 32'd0);
    check({tag, "_diff"}, 32'(diff8), 32'd0);
    check({tag, "_borrow"}, 32'(bor8), 32'd0);
    check({tag, "_ovf"}, 32'(ovf8), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    check("reset_diff4", 32'(diff4), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed cases.
    issue8(8'h5A, 8'h23);
    issue8(8'h10, 8'h20);
    issue8(8'h00, 8'h00);
    issue8(8'h80, 8'h01);
    issue8(8'h7F, 8'hFF);
    issue8(8'hFF, 8'hFF);

    // start while busy is ignored; operands not recaptured.
    @(negedge clk);
    a8 = 8'h05; b8 = 8'h03; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'h11; b8 = 8'h22;
    repeat (8) @(negedge clk);

    // start held high with operands changing every cycle.
    start8 = 1'b1;
    repeat (45) begin
      a8 = 8'($urandom_range(0, 255));
      b8 = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    start8 = 1'b0;
    repeat (11) @(negedge clk);

    // Reset mid-operation: outputs clear at once, no done afterwards.
    a8 = 8'h07; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    repeat (3) @(negedge clk);
    check_zero_outputs("inreset");
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue8(8'h09, 8'h04);

    // Random transactions with random gaps.
    repeat (30) begin
      issue8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Exhaustive WIDTH=4 sweep, back-to-back with start held high.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a4 = 4'(i); b4 = 4'(j); start4 = 1'b1;
        repeat (5) @(negedge clk);
      end
    end
    start4 = 1'b0;

    // Drain with a bounded wait.
    begin
      int budget = 50;
      while ((exp8_q.size() != 0 || exp4_q.size() != 0) && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      check("drain_q8", 32'(exp8_q.size()), 32'd0);
      check("drain_q4", 32'(exp4_q.size()), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
